// File: rtl/dma_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dma_pkg
//  Description : Shared state encoding and bus constants for dma_bus_master.
//  Revision    : 1.0 - initial release
// ============================================================================
package dma_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] REGION_BUF = 4'h2;
    localparam logic [3:0] REGION_PIM = 4'h4;
    localparam logic [3:0] SIZE_WORD  = 4'hF;

endpackage
`default_nettype wire

// File: rtl/dma_bus_master.sv
`default_nettype none
// ============================================================================
//  Module      : dma_bus_master
//  Description : sys_bus DMA initiator copying LEN words between the PIM
//                buffer SRAM (port 0) and the Hybrid-PIM (port 1).
//  Revision    : 1.0 - initial release
// ============================================================================
module dma_bus_master
    import dma_pkg::*;
#(
    parameter int LEN_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             dir_i,
    input  logic [31:0]      src_addr_i,
    input  logic [31:0]      dst_addr_i,
    input  logic [LEN_W-1:0] len_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic             req_dma_o,
    input  logic             gnt_dma_i,
    output logic [31:0]      dma_addr_0_o,
    output logic             dma_write_0_o,
    output logic             dma_read_0_o,
    output logic [3:0]       dma_size_0_o,
    output logic [31:0]      dma_din_0_o,
    input  logic [31:0]      dma_dout_0_i,
    output logic [31:0]      dma_addr_1_o,
    output logic             dma_write_1_o,
    output logic             dma_read_1_o,
    output logic [3:0]       dma_size_1_o,
    output logic [31:0]      dma_din_1_o,
    input  logic [31:0]      dma_dout_1_i
);

    state_t             r_state,     w_state_nxt;
    logic               r_dir,       w_dir_nxt;
    logic [31:0]        r_src,       w_src_nxt;
    logic [31:0]        r_dst,       w_dst_nxt;
    logic [LEN_W-1:0]   r_len,       w_len_nxt;
    logic               r_err,       w_err_nxt;
    logic [LEN_W-1:0]   r_rd_cnt,    w_rd_cnt_nxt;
    logic [LEN_W-1:0]   r_wr_cnt,    w_wr_cnt_nxt;
    logic               r_rd_pend,   w_rd_pend_nxt;
    logic               r_hold_v,    w_hold_v_nxt;
    logic [31:0]        r_hold_data, w_hold_data_nxt;

    logic               w_cfg_err;
    logic               w_rd_issue;
    logic               w_wr_issue;
    logic [31:0]        w_wr_data;
    logic [31:0]        w_src_dout;
    logic [31:0]        w_rd_addr;
    logic [31:0]        w_wr_addr;

    // Source region must match the direction, destination the opposite one.
    assign w_cfg_err = (src_addr_i[31:28] != (dir_i ? REGION_PIM : REGION_BUF)) ||
                       (dst_addr_i[31:28] != (dir_i ? REGION_BUF : REGION_PIM)) ||
                       (src_addr_i[1:0] != 2'b00) || (dst_addr_i[1:0] != 2'b00);

    assign w_src_dout = r_dir ? dma_dout_1_i : dma_dout_0_i;
    assign w_rd_addr  = r_src + {{(30-LEN_W){1'b0}}, r_rd_cnt, 2'b00};
    assign w_wr_addr  = r_dst + {{(30-LEN_W){1'b0}}, r_wr_cnt, 2'b00};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= IDLE;
            r_dir       <= 1'b0;
            r_src       <= '0;
            r_dst       <= '0;
            r_len       <= '0;
            r_err       <= 1'b0;
            r_rd_cnt    <= '0;
            r_wr_cnt    <= '0;
            r_rd_pend   <= 1'b0;
            r_hold_v    <= 1'b0;
            r_hold_data <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_dir       <= w_dir_nxt;
            r_src       <= w_src_nxt;
            r_dst       <= w_dst_nxt;
            r_len       <= w_len_nxt;
            r_err       <= w_err_nxt;
            r_rd_cnt    <= w_rd_cnt_nxt;
            r_wr_cnt    <= w_wr_cnt_nxt;
            r_rd_pend   <= w_rd_pend_nxt;
            r_hold_v    <= w_hold_v_nxt;
            r_hold_data <= w_hold_data_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_dir_nxt       = r_dir;
        w_src_nxt       = r_src;
        w_dst_nxt       = r_dst;
        w_len_nxt       = r_len;
        w_err_nxt       = r_err;
        w_rd_cnt_nxt    = r_rd_cnt;
        w_wr_cnt_nxt    = r_wr_cnt;
        w_rd_pend_nxt   = 1'b0;
        w_hold_v_nxt    = r_hold_v;
        w_hold_data_nxt = r_hold_data;
        w_rd_issue      = 1'b0;
        w_wr_issue      = 1'b0;
        w_wr_data       = '0;
        busy_o          = 1'b0;
        done_o          = 1'b0;
        req_dma_o       = 1'b0;
        err_o           = r_err;

        unique case (r_state)
            IDLE: begin
                if (start_i) begin
                    w_dir_nxt    = dir_i;
                    w_src_nxt    = src_addr_i;
                    w_dst_nxt    = dst_addr_i;
                    w_len_nxt    = len_i;
                    w_err_nxt    = w_cfg_err;
                    w_rd_cnt_nxt = '0;
                    w_wr_cnt_nxt = '0;
                    w_hold_v_nxt = 1'b0;
                    w_state_nxt  = (w_cfg_err || (len_i == '0)) ? DONE : RUN;
                end
            end
            RUN: begin
                busy_o     = 1'b1;
                req_dma_o  = 1'b1;
                // A held word drains in the same granted cycle, so a new read may follow it.
                w_rd_issue = gnt_dma_i && (r_rd_cnt < r_len) && (!r_hold_v || gnt_dma_i);
                if (gnt_dma_i && r_hold_v) begin
                    w_wr_issue   = 1'b1;
                    w_wr_data    = r_hold_data;
                    w_hold_v_nxt = 1'b0;
                end else if (gnt_dma_i && r_rd_pend) begin
                    w_wr_issue = 1'b1;
                    w_wr_data  = w_src_dout;
                end else if (r_rd_pend) begin
                    w_hold_v_nxt    = 1'b1;
                    w_hold_data_nxt = w_src_dout;
                end
                w_rd_pend_nxt = w_rd_issue;
                if (w_rd_issue) begin
                    w_rd_cnt_nxt = r_rd_cnt + LEN_W'(1);
                end
                if (w_wr_issue) begin
                    w_wr_cnt_nxt = r_wr_cnt + LEN_W'(1);
                    if ((r_wr_cnt + LEN_W'(1)) == r_len) begin
                        w_state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                done_o      = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Port steering: the source port only reads, the destination port only writes.
    always_comb begin
        dma_addr_0_o  = '0;
        dma_write_0_o = 1'b0;
        dma_read_0_o  = 1'b0;
        dma_size_0_o  = '0;
        dma_din_0_o   = '0;
        dma_addr_1_o  = '0;
        dma_write_1_o = 1'b0;
        dma_read_1_o  = 1'b0;
        dma_size_1_o  = '0;
        dma_din_1_o   = '0;
        if (w_rd_issue) begin
            if (r_dir) begin
                dma_read_1_o = 1'b1;
                dma_addr_1_o = w_rd_addr;
                dma_size_1_o = SIZE_WORD;
            end else begin
                dma_read_0_o = 1'b1;
                dma_addr_0_o = w_rd_addr;
                dma_size_0_o = SIZE_WORD;
            end
        end
        if (w_wr_issue) begin
            if (r_dir) begin
                dma_write_0_o = 1'b1;
                dma_addr_0_o  = w_wr_addr;
                dma_size_0_o  = SIZE_WORD;
                dma_din_0_o   = w_wr_data;
            end else begin
                dma_write_1_o = 1'b1;
                dma_addr_1_o  = w_wr_addr;
                dma_size_1_o  = SIZE_WORD;
                dma_din_1_o   = w_wr_data;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dma_bus_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dma_bus_master
//  Description : Scoreboard bench for dma_bus_master with sync-read bus models.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dma_bus_master;

    logic        clk_i = 1'b0;
    logic        rst_i, start_i, dir_i, gnt_dma_i;
    logic [31:0] src_addr_i, dst_addr_i;
    logic [15:0] len_i;
    logic        busy_o, done_o, err_o, req_dma_o;
    logic [31:0] dma_addr_0_o, dma_din_0_o, dma_dout_0_i;
    logic [31:0] dma_addr_1_o, dma_din_1_o, dma_dout_1_i;
    logic        dma_write_0_o, dma_read_0_o, dma_write_1_o, dma_read_1_o;
    logic [3:0]  dma_size_0_o, dma_size_1_o;

    typedef struct {
        logic        port;
        logic [31:0] addr;
        logic [31:0] data;
    } acc_t;

    acc_t rd_q[$];
    acc_t wr_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_writes = 0;
    int   n_cyc    = 0;

    always #5 clk_i = ~clk_i;

    dma_bus_master #(.LEN_W(16)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .dir_i(dir_i),
        .src_addr_i(src_addr_i), .dst_addr_i(dst_addr_i), .len_i(len_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .req_dma_o(req_dma_o),
        .gnt_dma_i(gnt_dma_i),
        .dma_addr_0_o(dma_addr_0_o), .dma_write_0_o(dma_write_0_o), .dma_read_0_o(dma_read_0_o),
        .dma_size_0_o(dma_size_0_o), .dma_din_0_o(dma_din_0_o), .dma_dout_0_i(dma_dout_0_i),
        .dma_addr_1_o(dma_addr_1_o), .dma_write_1_o(dma_write_1_o), .dma_read_1_o(dma_read_1_o),
        .dma_size_1_o(dma_size_1_o), .dma_din_1_o(dma_din_1_o), .dma_dout_1_i(dma_dout_1_i)
    );

    function automatic logic [31:0] mem_data(input logic port, input logic [31:0] addr);
        return (addr * 32'h9E37_79B9) ^ (port ? 32'h5A5A_1234 : 32'hC3C3_8765);
    endfunction

    // Sync-read memories: data valid the cycle after the read, junk otherwise.
    initial begin
        dma_dout_0_i = '0;
        dma_dout_1_i = '0;
        forever begin
            @(posedge clk_i);
            n_cyc <= n_cyc + 1;
            dma_dout_0_i <= dma_read_0_o ? mem_data(1'b0, dma_addr_0_o) : (32'hBAD0_0000 | n_cyc);
            dma_dout_1_i <= dma_read_1_o ? mem_data(1'b1, dma_addr_1_o) : (32'hBAD1_0000 | n_cyc);
        end
    end

    // Bus monitor: protocol rules every cycle, reads and writes against the scoreboard.
    initial begin
        acc_t e;
        logic bad;
        forever begin
            @(negedge clk_i);
            bad = (!gnt_dma_i && (dma_read_0_o || dma_write_0_o || dma_read_1_o || dma_write_1_o)) ||
                  (!(dma_read_0_o || dma_write_0_o) && dma_addr_0_o != 32'h0) ||
                  (!(dma_read_1_o || dma_write_1_o) && dma_addr_1_o != 32'h0) ||
                  (!dma_write_0_o && dma_din_0_o != 32'h0) || (!dma_write_1_o && dma_din_1_o != 32'h0) ||
                  ((dma_read_0_o || dma_write_0_o) && dma_size_0_o != 4'hF) ||
                  ((dma_read_1_o || dma_write_1_o) && dma_size_1_o != 4'hF);
            n_checks++;
            if (bad) $display("FAIL bus_protocol t=%0t gnt=%b r0=%b w0=%b a0=%h d0=%h s0=%h r1=%b w1=%b a1=%h d1=%h s1=%h (required: no access without grant, idle addr/din 0, size F)",
                              $time, gnt_dma_i, dma_read_0_o, dma_write_0_o, dma_addr_0_o, dma_din_0_o, dma_size_0_o,
                              dma_read_1_o, dma_write_1_o, dma_addr_1_o, dma_din_1_o, dma_size_1_o);
            else n_pass++;
            for (int p = 0; p < 2; p++) begin
                logic        rd, wr;
                logic [31:0] a, d;
                rd = (p == 0) ? dma_read_0_o  : dma_read_1_o;
                wr = (p == 0) ? dma_write_0_o : dma_write_1_o;
                a  = (p == 0) ? dma_addr_0_o  : dma_addr_1_o;
                d  = (p == 0) ? dma_din_0_o   : dma_din_1_o;
                if (rd) begin
                    n_checks++;
                    if (rd_q.size() == 0) begin
                        $display("FAIL read_unexpected port=%0d addr=%h (required: no read)", p, a);
                    end else begin
                        e = rd_q.pop_front();
                        if (e.port !== 1'(p) || e.addr !== a)
                            $display("FAIL read_addr port=%0d addr=%h required port=%0d addr=%h", p, a, e.port, e.addr);
                        else n_pass++;
                    end
                end
                if (wr) begin
                    n_writes++;
                    n_checks++;
                    if (wr_q.size() == 0) begin
                        $display("FAIL write_unexpected port=%0d addr=%h data=%h (required: no write)", p, a, d);
                    end else begin
                        e = wr_q.pop_front();
                        if (e.port !== 1'(p) || e.addr !== a || e.data !== d)
                            $display("FAIL write port=%0d addr=%h data=%h required port=%0d addr=%h data=%h",
                                     p, a, d, e.port, e.addr, e.data);
                        else n_pass++;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Drives a start pulse; returns one cycle later with start_i low.
    task automatic do_start(input logic d, input logic [31:0] s, input logic [31:0] t,
                            input logic [15:0] l, input bit expect_run);
        acc_t e;
        if (expect_run) begin
            for (int i = 0; i < int'(l); i++) begin
                e.port = d;
                e.addr = s + 32'(i * 4);
                e.data = '0;
                rd_q.push_back(e);
                e.port = ~d;
                e.addr = t + 32'(i * 4);
                e.data = mem_data(d, s + 32'(i * 4));
                wr_q.push_back(e);
            end
        end
        dir_i = d; src_addr_i = s; dst_addr_i = t; len_i = l;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic wait_done(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            if (done_o) seen = 1'b1;
            else tick();
        end
    endtask

    task automatic test_reset();
        logic [175:0] outs;
        rst_i = 1'b1; start_i = 1'b0; dir_i = 1'b0; gnt_dma_i = 1'b1;
        src_addr_i = '0; dst_addr_i = '0; len_i = '0;
        tick(); tick();
        outs = {busy_o, done_o, err_o, req_dma_o, dma_read_0_o, dma_write_0_o, dma_read_1_o, dma_write_1_o,
                dma_addr_0_o, dma_addr_1_o, dma_din_0_o, dma_din_1_o, dma_size_0_o, dma_size_1_o};
        n_checks++;
        if (outs !== '0) $display("FAIL reset_outputs got=%h required=0", outs);
        else n_pass++;
        rst_i = 1'b0;
        tick();
        n_checks++;
        if ({busy_o, done_o, err_o, req_dma_o} !== 4'b0000)
            $display("FAIL idle_after_reset busy/done/err/req=%b required=0000", {busy_o, done_o, err_o, req_dma_o});
        else n_pass++;
    endtask

    task automatic test_basic();
        logic [3:0] got, exp;
        gnt_dma_i = 1'b1;
        do_start(1'b0, 32'h2000_0000, 32'h4000_0000, 16'd4, 1'b1);
        for (int c = 1; c <= 7; c++) begin
            got = {dma_read_0_o, dma_write_1_o, busy_o, done_o};
            exp = {c <= 4, c >= 2 && c <= 5, c <= 5, c == 6};
            n_checks++;
            if (got !== exp) $display("FAIL basic_timing cycle=%0d rd/wr/busy/done=%b required=%b", c, got, exp);
            else n_pass++;
            tick();
        end
        n_checks++;
        if (rd_q.size() != 0 || wr_q.size() != 0)
            $display("FAIL basic_drain pending rd=%0d wr=%0d required 0/0", rd_q.size(), wr_q.size());
        else n_pass++;
    endtask

    task automatic test_gnt_drop();
        logic [4:0] got, exp;
        gnt_dma_i = 1'b1;
        do_start(1'b0, 32'h2000_0040, 32'h4000_0080, 16'd4, 1'b1);
        for (int c = 1; c <= 10; c++) begin
            gnt_dma_i = !(c >= 3 && c <= 5);
            #1;
            got = {dma_read_0_o, dma_write_1_o, busy_o, done_o, req_dma_o};
            exp = {c == 1 || c == 2 || c == 6 || c == 7, c == 2 || c == 6 || c == 7 || c == 8,
                   c <= 8, c == 9, c <= 8};
            n_checks++;
            if (got !== exp) $display("FAIL gnt_drop_timing cycle=%0d rd/wr/busy/done/req=%b required=%b", c, got, exp);
            else n_pass++;
            tick();
        end
        gnt_dma_i = 1'b1;
        n_checks++;
        if (rd_q.size() != 0 || wr_q.size() != 0)
            $display("FAIL gnt_drop_drain pending rd=%0d wr=%0d required 0/0", rd_q.size(), wr_q.size());
        else n_pass++;
    endtask

    task automatic test_dir1();
        bit seen;
        int w0;
        w0 = n_writes;
        gnt_dma_i = 1'b1;
        do_start(1'b1, 32'h4000_0010, 32'h2000_4000, 16'd2, 1'b1);
        wait_done(seen);
        n_checks++;
        if (!seen) $display("FAIL dir1_done timeout got=0 required=1");
        else n_pass++;
        tick();
        n_checks++;
        if (n_writes - w0 != 2 || wr_q.size() != 0)
            $display("FAIL dir1_writes got=%0d pending=%0d required 2/0", n_writes - w0, wr_q.size());
        else n_pass++;
    endtask

    task automatic test_len0_err();
        logic [3:0] got;
        gnt_dma_i = 1'b1;
        do_start(1'b0, 32'h2000_0000, 32'h4000_0000, 16'd0, 1'b0);
        got = {done_o, err_o, req_dma_o, busy_o};
        n_checks++;
        if (got !== 4'b1000) $display("FAIL len0 done/err/req/busy=%b required=1000", got);
        else n_pass++;
        tick();
        got = {done_o, err_o, req_dma_o, busy_o};
        n_checks++;
        if (got !== 4'b0000) $display("FAIL len0_after done/err/req/busy=%b required=0000", got);
        else n_pass++;
        do_start(1'b0, 32'h1000_0000, 32'h4000_0000, 16'd4, 1'b0);
        got = {done_o, err_o, req_dma_o, busy_o};
        n_checks++;
        if (got !== 4'b1100) $display("FAIL region_err done/err/req/busy=%b required=1100", got);
        else n_pass++;
        tick(); tick();
        got = {done_o, err_o, req_dma_o, busy_o};
        n_checks++;
        if (got !== 4'b0100) $display("FAIL err_sticky done/err/req/busy=%b required=0100", got);
        else n_pass++;
        do_start(1'b1, 32'h4000_0000, 32'h2000_0002, 16'd3, 1'b0);
        got = {done_o, err_o, req_dma_o, busy_o};
        n_checks++;
        if (got !== 4'b1100) $display("FAIL align_err done/err/req/busy=%b required=1100", got);
        else n_pass++;
        tick();
    endtask

    task automatic test_reset_mid();
        logic [175:0] outs;
        bit seen;
        gnt_dma_i = 1'b1;
        do_start(1'b0, 32'h2000_0200, 32'h4000_0300, 16'd8, 1'b1);
        tick(); tick();
        rst_i = 1'b1;
        tick();
        outs = {busy_o, done_o, err_o, req_dma_o, dma_read_0_o, dma_write_0_o, dma_read_1_o, dma_write_1_o,
                dma_addr_0_o, dma_addr_1_o, dma_din_0_o, dma_din_1_o, dma_size_0_o, dma_size_1_o};
        n_checks++;
        if (outs !== '0) $display("FAIL mid_reset_outputs got=%h required=0", outs);
        else n_pass++;
        rd_q.delete();
        wr_q.delete();
        rst_i = 1'b0;
        tick();
        do_start(1'b0, 32'h2000_0400, 32'h4000_0500, 16'd3, 1'b1);
        wait_done(seen);
        n_checks++;
        if (!seen || err_o !== 1'b0) $display("FAIL restart done_seen=%0d err=%b required 1/0", seen, err_o);
        else n_pass++;
        tick();
        n_checks++;
        if (rd_q.size() != 0 || wr_q.size() != 0)
            $display("FAIL restart_drain pending rd=%0d wr=%0d required 0/0", rd_q.size(), wr_q.size());
        else n_pass++;
    endtask

    task automatic test_start_busy();
        bit seen;
        int w0;
        w0 = n_writes;
        gnt_dma_i = 1'b1;
        do_start(1'b0, 32'h2000_0100, 32'h4000_0200, 16'd5, 1'b1);
        tick();
        dir_i = 1'b1; src_addr_i = 32'h4000_0800; dst_addr_i = 32'h2000_0900; len_i = 16'd9;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        wait_done(seen);
        for (int i = 0; i < 5; i++) tick();
        n_checks++;
        if (!seen || n_writes - w0 != 5 || wr_q.size() != 0 || busy_o !== 1'b0)
            $display("FAIL start_while_busy done_seen=%0d writes=%0d pending=%0d busy=%b required 1/5/0/0",
                     seen, n_writes - w0, wr_q.size(), busy_o);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gnt_drop();
        test_dir1();
        test_len0_err();
        test_reset_mid();
        test_start_busy();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
